// File: rtl/rsa_modexp_engine.sv
// Modular exponentiation Result = Data^Key mod N, right-to-left square-and-multiply.
// Optional macro RSA_EARLY_EXIT_EN stops once the remaining key bits are all zero.
module rsa_modexp_engine #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Start,
    input  logic [WIDTH-1:0] Data,
    input  logic [WIDTH-1:0] N,
    input  logic [WIDTH-1:0] Key,
    output logic [WIDTH-1:0] Result,
    output logic             Done,
    output logic             Busy,
    output logic             Error
);

    localparam int PW = WIDTH + 2;
    localparam int CW = $clog2(WIDTH + 1) + 1;
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_REDUCE,
        S_EXP,
        S_FINISH
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] data_r, n_r, key_r;
    logic [WIDTH-1:0] acc, base, a_sh;
    logic [PW-1:0]    p_mul, p_sq;
    logic [PW-1:0]    mul_next, sq_next;
    logic [CW-1:0]    cnt, iter;
    logic             accept;
    logic             step_last;
    logic             iter_last;
    logic             key_rest_zero;

    // One interleaved step: P < N on entry keeps 2P + B below 3N.
    function automatic logic [PW-1:0] mm_step(
        input logic [PW-1:0]    p,
        input logic             a_bit,
        input logic [WIDTH-1:0] b,
        input logic [WIDTH-1:0] n
    );
        logic [PW-1:0] t;
        logic [PW-1:0] nn;
        nn = {2'b00, n};
        t  = (p << 1) + (a_bit ? {2'b00, b} : '0);
        if (t >= nn) t = t - nn;
        if (t >= nn) t = t - nn;
        return t;
    endfunction

    assign accept        = (state == S_IDLE) && Start && !Busy;
    assign step_last     = (cnt == CW'(WIDTH - 1));
    assign iter_last     = (iter == CW'(WIDTH - 1));
    assign key_rest_zero = (key_r[WIDTH-1:1] == '0);

    // The reduce pass reuses the squaring multiplier with B = 1.
    assign sq_next  = mm_step(p_sq, a_sh[WIDTH-1],
                              (state == S_REDUCE) ? ONE : base, n_r);
    assign mul_next = mm_step(p_mul, a_sh[WIDTH-1], acc, n_r);

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE: begin
                if (accept) state_next = S_LOAD;
            end
            S_LOAD: begin
                if (n_r < WIDTH'(2)) state_next = S_FINISH;
                else                 state_next = S_REDUCE;
            end
            S_REDUCE: begin
                if (step_last) begin
`ifdef RSA_EARLY_EXIT_EN
                    if (key_r == '0) state_next = S_FINISH;
                    else             state_next = S_EXP;
`else
                    state_next = S_EXP;
`endif
                end
            end
            S_EXP: begin
                if (cnt == CW'(WIDTH)) begin
                    if (iter_last) state_next = S_FINISH;
`ifdef RSA_EARLY_EXIT_EN
                    if (key_rest_zero) state_next = S_FINISH;
`endif
                end
            end
            S_FINISH: state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_r <= '0;
            n_r    <= '0;
            key_r  <= '0;
            acc    <= '0;
            base   <= '0;
            a_sh   <= '0;
            p_mul  <= '0;
            p_sq   <= '0;
            cnt    <= '0;
            iter   <= '0;
            Result <= '0;
            Done   <= 1'b0;
            Busy   <= 1'b0;
            Error  <= 1'b0;
        end else begin
            Done <= 1'b0;
            if (accept)    Busy <= 1'b1;
            else if (Done) Busy <= 1'b0;

            unique case (state)
                S_IDLE: begin
                    if (accept) begin
                        data_r <= Data;
                        n_r    <= N;
                        key_r  <= Key;
                        Error  <= 1'b0;
                    end
                end
                S_LOAD: begin
                    cnt  <= '0;
                    iter <= '0;
                    p_sq <= '0;
                    a_sh <= data_r;
                    if (n_r < WIDTH'(2)) begin
                        acc   <= '0;
                        Error <= (n_r == '0);
                    end else begin
                        acc <= ONE;
                    end
                end
                S_REDUCE: begin
                    if (step_last) begin
                        base  <= sq_next[WIDTH-1:0];
                        a_sh  <= sq_next[WIDTH-1:0];
                        p_sq  <= '0;
                        p_mul <= '0;
                        cnt   <= '0;
                    end else begin
                        p_sq <= sq_next;
                        a_sh <= a_sh << 1;
                        cnt  <= cnt + CW'(1);
                    end
                end
                S_EXP: begin
                    if (cnt == CW'(WIDTH)) begin
                        if (key_r[0]) acc <= p_mul[WIDTH-1:0];
                        base  <= p_sq[WIDTH-1:0];
                        a_sh  <= p_sq[WIDTH-1:0];
                        key_r <= key_r >> 1;
                        p_sq  <= '0;
                        p_mul <= '0;
                        cnt   <= '0;
                        iter  <= iter + CW'(1);
                    end else begin
                        p_sq  <= sq_next;
                        p_mul <= mul_next;
                        a_sh  <= a_sh << 1;
                        cnt   <= cnt + CW'(1);
                    end
                end
                S_FINISH: begin
                    Result <= acc;
                    Done   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
